msm_point_accumulator: RTL and testbench
========================================

# msm_point_accumulator

Sums a stream of elliptic-curve points from `point_mul_double_and_add` into one result point per batch. This is the reduction stage of the MSM datapath: Σ kᵢ·Pᵢ. Points arrive on a valid/ready handshake. Each point is folded into an affine accumulator, and the identity is tracked by a flag. The accumulator chooses between a pass-through load, an affine add or a double, and drives the team's `point_add` and `point_double` units (start/done) for the arithmetic.

## Interface
Parameters:
- `P_WIDTH`, package default (377): coordinate width.
- `COUNT_WIDTH`, 16: width of the batch point counter.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `Reset_n`  in  1  one clock; reset is synchronous and active-low.
- `in_valid`  in  1  `in_point` is valid.
- `in_ready`  out  1  accumulator can take a point this cycle.
- `in_point`  in  2×P_WIDTH  affine point {x, y} (`point_t`).
- `in_inf`  in  1  input is the point at infinity; `in_point` is ignored.
- `in_last`  in  1  final point of the batch.
- `out_valid`  out  1  batch result is valid.
- `out_ready`  in  1  consumer takes the result.
- `out_point`  out  2×P_WIDTH  batch sum.
- `out_inf`  out  1  batch sum is infinity.
- `count`  out  COUNT_WIDTH  points accepted in the current batch.
- `busy`  out  1  FSM is not in ACCEPT.

## Operation
- State: `acc` (`point_t`), `acc_inf`, `last_q`, and `count`. FSM states are ACCEPT, ADD_WAIT, DBL_WAIT and OUTPUT.
- `in_ready` = 1 only in ACCEPT with `Reset_n` = 1. A transfer is `in_valid & in_ready`.
- On transfer, in priority order:
  - `in_inf` = 1: no change to `acc`.
  - `acc_inf` = 1: `acc` <= `in_point`, `acc_inf` <= 0.
  - x equal, y equal, y ≠ 0: go to DBL_WAIT.
  - x equal otherwise (P + (−P), or y = 0): `acc_inf` <= 1.
  - else: go to ADD_WAIT.
- Every transfer also latches `last_q` <= `in_last` and increments `count`; `count` saturates at all-ones.
- ADD_WAIT / DBL_WAIT:
  - `start` is a one-cycle pulse on the first cycle in the state.
  - Operands are `acc` and the latched input point.
  - On `done`, `acc` <= the sub-module result.
  - Next state is OUTPUT if `last_q`, else ACCEPT.
- Non-arithmetic transfers go directly to OUTPUT (if `in_last`) or stay in ACCEPT.
- OUTPUT:
  - `out_valid` = 1, `out_point` = `acc`, `out_inf` = `acc_inf`, all held stable until `out_ready`.
  - On handshake: `acc_inf` <= 1, `acc` <= 0, `count` <= 0, next state ACCEPT.
- All arithmetic is mod p, inside the sub-units. Coordinate compares are full-width equality.

## Timing
- Reset (`Reset_n` = 0 at an edge):
  - state = ACCEPT, `acc` = 0, `acc_inf` = 1, `count` = 0.
  - `out_valid` = 0, `out_point` = 0, `out_inf` = 0, `busy` = 0, `in_ready` = 0 while reset is held.
  - `in_ready` = 1 on the first cycle after release.
- Reset mid-operation aborts the add/double. Sub-units are held in reset via `Reset_n`, and no result is emitted.
- Load or infinity transfer at cycle T:
  - `acc` updates at T+1.
  - `in_ready` stays 1 at T+1 when not last.
  - If last, `out_valid` = 1 at T+1.
- Arithmetic transfer at T:
  - state changes at T+1 with `start` = 1 at T+1.
  - `done` arrives at T+1+L.
  - `acc` and state update at T+2+L, which is when `in_ready` or `out_valid` rises.
- `out_valid` never drops without `out_ready`. The cycle after the output handshake, `in_ready` = 1.
- The FSM ignores `done` outside the WAIT states.

## Structure
- `point_t`, `P_WIDTH` and `params` (p, `base_point`) live in `elliptic_curve_structs`. The FSM state enum is local to the block.
- One instance each of `point_add` and `point_double`; no new sub-module.
- The sub-units need a start/done wrapper; the common wrapper goes in the shared package.

## Test plan
- G (`params.base_point`), `in_last` = 1 → `out_valid` on the next cycle, `out_point` = G, `out_inf` = 0, `count` = 1, no `start` pulse.
- G, G (last) → one `point_double` start; `out_point` equals `point_mul_double_and_add` with k = 2.
- G, 2G, G (last) → `out_point` equals the k = 4 multiplier result, `count` = 3.
- G, then (Gx, p − Gy) last → `out_inf` = 1, no adder start.
- `in_inf`, G, `in_inf` (last) → `out_point` = G, `count` = 3; hold `out_ready` = 0 for 10 cycles → `out_valid` and data stable, `in_ready` = 0.
- `Reset_n` = 0 for 1 cycle during ADD_WAIT → all outputs 0 next cycle, `in_ready` = 1 after release; a following single-G batch returns G.

Source files
------------

// File: rtl/msm_point_accumulator_pkg.sv
// Curve types and parameters, plus the modular-arithmetic and inversion helpers
// shared by the point_add / point_double start-done wrappers.
package elliptic_curve_structs;
  localparam int P_WIDTH = 377;
  typedef logic [P_WIDTH-1:0] fe_t;
  typedef struct packed { fe_t x; fe_t y; } point_t;
  typedef struct packed { fe_t p; fe_t a; point_t base_point; } curve_params_t;

  // BLS12-377 G1: y^2 = x^3 + 1
  localparam curve_params_t params = '{
    p: 377'h1ae3a4617c510eac63b05c06ca1493b1a22d9f300f5138f1ef3622fba094800170b5d44300000008508c00000000001,
    a: 377'h0,
    base_point: '{
      x: 377'h8848defe740a67c8fc6225bf87ff5485951e2caa9d41bb188282c8bd37cb5cd5481512ffcd394eeab9b16eb21be9ef,
      y: 377'h1914a69c5102eff1f674f5d30afeec4bd7fb348ca3e52d96d182ad44fb82305c2fe3d3634a9591afd82de55559c8ea6
    }
  };
endpackage

package msm_point_accumulator_pkg;
  import elliptic_curve_structs::*;

  typedef fe_t    field_t;
  typedef point_t field_point_t;
  localparam field_t DEFAULT_P = params.p;
  localparam field_t DEFAULT_A = params.a;

  // Binary extended-Euclid state; invariants x1*den = u and x2*den = v (mod p).
  typedef struct packed { fe_t u; fe_t v; fe_t x1; fe_t x2; } inv_state_t;

  function automatic fe_t mod_add(input fe_t a, input fe_t b, input fe_t p);
    logic [P_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, p}) s = s - {1'b0, p};
    return fe_t'(s);
  endfunction

  function automatic fe_t mod_sub(input fe_t a, input fe_t b, input fe_t p);
    return (a >= b) ? fe_t'(a - b) : fe_t'(a + (p - b));
  endfunction

  function automatic fe_t mod_mul(input fe_t a, input fe_t b, input fe_t p);
    logic [2*P_WIDTH-1:0] prod;
    prod = {{P_WIDTH{1'b0}}, a} * {{P_WIDTH{1'b0}}, b};
    return fe_t'(prod % {{P_WIDTH{1'b0}}, p});
  endfunction

  function automatic fe_t mod_half(input fe_t a, input fe_t p);
    logic [P_WIDTH:0] s;
    s = a[0] ? ({1'b0, a} + {1'b0, p}) : {1'b0, a};
    return fe_t'(s >> 1);
  endfunction

  function automatic inv_state_t inv_init(input fe_t den, input fe_t p);
    return '{u: den, v: p, x1: fe_t'(1), x2: fe_t'(0)};
  endfunction

  function automatic inv_state_t inv_step(input inv_state_t s, input fe_t p);
    inv_state_t n;
    n = s;
    if (!s.u[0]) begin
      n.u  = s.u >> 1;
      n.x1 = mod_half(s.x1, p);
    end else if (!s.v[0]) begin
      n.v  = s.v >> 1;
      n.x2 = mod_half(s.x2, p);
    end else if (s.u >= s.v) begin
      n.u  = s.u - s.v;
      n.x1 = mod_sub(s.x1, s.x2, p);
    end else begin
      n.v  = s.v - s.u;
      n.x2 = mod_sub(s.x2, s.x1, p);
    end
    return n;
  endfunction

  // u == 0 only for a zero denominator; finishing there avoids a stuck unit.
  function automatic logic inv_done(input inv_state_t s);
    return (s.u == fe_t'(1)) || (s.v == fe_t'(1)) || (s.u == fe_t'(0));
  endfunction

  function automatic fe_t inv_result(input inv_state_t s);
    return (s.u == fe_t'(1)) ? s.x1 : ((s.v == fe_t'(1)) ? s.x2 : fe_t'(0));
  endfunction

  function automatic point_t ec_finish(input fe_t lam, input fe_t x1, input fe_t y1,
                                       input fe_t x2, input fe_t p);
    point_t r;
    r.x = mod_sub(mod_sub(mod_mul(lam, lam, p), x1, p), x2, p);
    r.y = mod_sub(mod_mul(lam, mod_sub(x1, r.x, p), p), y1, p);
    return r;
  endfunction
endpackage

// File: rtl/msm_point_accumulator_units.sv
// Start/done affine point adder and doubler; the slope denominator is inverted
// one binary-Euclid step per cycle, so latency depends on the operands.
module point_add
  import elliptic_curve_structs::*;
  import msm_point_accumulator_pkg::*;
#(
  parameter fe_t P_MOD = DEFAULT_P
) (
  input  logic   clk,
  input  logic   Reset_n,
  input  logic   start,
  input  point_t p1,
  input  point_t p2,
  output logic   done,
  output point_t result
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_INV  = 1'b1;

  logic [0:0] r_state;
  inv_state_t r_inv;
  fe_t        r_num;
  point_t     r_p1, r_p2, r_result;
  logic       r_done;

  // Load operands on start, iterate the inversion, then form P1 + P2.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      r_state  <= ST_IDLE;
      r_inv    <= '0;
      r_num    <= '0;
      r_p1     <= '0;
      r_p2     <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_inv   <= inv_init(mod_sub(p2.x, p1.x, P_MOD), P_MOD);
            r_num   <= mod_sub(p2.y, p1.y, P_MOD);
            r_p1    <= p1;
            r_p2    <= p2;
            r_state <= ST_INV;
          end
        end
        ST_INV: begin
          if (inv_done(r_inv)) begin
            r_result <= ec_finish(mod_mul(r_num, inv_result(r_inv), P_MOD),
                                  r_p1.x, r_p1.y, r_p2.x, P_MOD);
            r_done   <= 1'b1;
            r_state  <= ST_IDLE;
          end else begin
            r_inv <= inv_step(r_inv, P_MOD);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign done   = r_done;
  assign result = r_result;
endmodule

module point_double
  import elliptic_curve_structs::*;
  import msm_point_accumulator_pkg::*;
#(
  parameter fe_t P_MOD   = DEFAULT_P,
  parameter fe_t CURVE_A = DEFAULT_A
) (
  input  logic   clk,
  input  logic   Reset_n,
  input  logic   start,
  input  point_t p1,
  output logic   done,
  output point_t result
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_INV  = 1'b1;

  logic [0:0] r_state;
  inv_state_t r_inv;
  fe_t        r_num;
  point_t     r_p1, r_result;
  logic       r_done;
  fe_t        w_sq;

  assign w_sq = mod_mul(p1.x, p1.x, P_MOD);

  // Slope is (3x^2 + a) / 2y; same inversion loop as the adder.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      r_state  <= ST_IDLE;
      r_inv    <= '0;
      r_num    <= '0;
      r_p1     <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_inv   <= inv_init(mod_add(p1.y, p1.y, P_MOD), P_MOD);
            r_num   <= mod_add(mod_add(mod_add(w_sq, w_sq, P_MOD), w_sq, P_MOD), CURVE_A, P_MOD);
            r_p1    <= p1;
            r_state <= ST_INV;
          end
        end
        ST_INV: begin
          if (inv_done(r_inv)) begin
            r_result <= ec_finish(mod_mul(r_num, inv_result(r_inv), P_MOD),
                                  r_p1.x, r_p1.y, r_p1.x, P_MOD);
            r_done   <= 1'b1;
            r_state  <= ST_IDLE;
          end else begin
            r_inv <= inv_step(r_inv, P_MOD);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign done   = r_done;
  assign result = r_result;
endmodule

// File: rtl/msm_point_accumulator.sv
// Folds a valid/ready stream of affine points into one sum per batch, using
// point_add / point_double for the arithmetic and a flag for the identity.
module msm_point_accumulator
  import msm_point_accumulator_pkg::*;
#(
  parameter int     P_WIDTH     = elliptic_curve_structs::P_WIDTH,
  parameter int     COUNT_WIDTH = 16,
  parameter field_t P_MOD       = DEFAULT_P,
  parameter field_t CURVE_A     = DEFAULT_A
) (
  input  logic                   clk,
  input  logic                   Reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*P_WIDTH-1:0]   in_point,
  input  logic                   in_inf,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*P_WIDTH-1:0]   out_point,
  output logic                   out_inf,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   busy
);
  localparam logic [1:0] ST_ACCEPT   = 2'd0;
  localparam logic [1:0] ST_ADD_WAIT = 2'd1;
  localparam logic [1:0] ST_DBL_WAIT = 2'd2;
  localparam logic [1:0] ST_OUTPUT   = 2'd3;

  logic [1:0]             r_state;
  logic [P_WIDTH-1:0]     r_acc_x, r_acc_y, r_in_x, r_in_y;
  logic                   r_acc_inf, r_last, r_start;
  logic [COUNT_WIDTH-1:0] r_count;

  logic [P_WIDTH-1:0] w_in_x, w_in_y;
  logic               w_xfer, w_x_eq, w_y_eq, w_y_zero;
  logic               w_add_start, w_dbl_start, w_add_done, w_dbl_done;
  field_point_t       w_acc_pt, w_in_pt, w_add_res, w_dbl_res;

  assign w_in_x   = in_point[2*P_WIDTH-1:P_WIDTH];
  assign w_in_y   = in_point[P_WIDTH-1:0];
  assign in_ready = Reset_n && (r_state == ST_ACCEPT);
  assign w_xfer   = in_valid && in_ready;
  assign w_x_eq   = (w_in_x == r_acc_x);
  assign w_y_eq   = (w_in_y == r_acc_y);
  assign w_y_zero = (r_acc_y == '0);

  assign w_acc_pt    = '{x: field_t'(r_acc_x), y: field_t'(r_acc_y)};
  assign w_in_pt     = '{x: field_t'(r_in_x), y: field_t'(r_in_y)};
  assign w_add_start = r_start && (r_state == ST_ADD_WAIT);
  assign w_dbl_start = r_start && (r_state == ST_DBL_WAIT);

  point_add #(.P_MOD(P_MOD)) u_add (
    .clk(clk), .Reset_n(Reset_n), .start(w_add_start),
    .p1(w_acc_pt), .p2(w_in_pt), .done(w_add_done), .result(w_add_res)
  );

  point_double #(.P_MOD(P_MOD), .CURVE_A(CURVE_A)) u_dbl (
    .clk(clk), .Reset_n(Reset_n), .start(w_dbl_start),
    .p1(w_acc_pt), .done(w_dbl_done), .result(w_dbl_res)
  );

  // Batch FSM: classify each accepted point, wait on the arithmetic unit, hold the result.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      r_state   <= ST_ACCEPT;
      r_acc_x   <= '0;
      r_acc_y   <= '0;
      r_acc_inf <= 1'b1;
      r_in_x    <= '0;
      r_in_y    <= '0;
      r_last    <= 1'b0;
      r_start   <= 1'b0;
      r_count   <= '0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        ST_ACCEPT: begin
          if (w_xfer) begin
            r_last <= in_last;
            r_in_x <= w_in_x;
            r_in_y <= w_in_y;
            if (r_count != {COUNT_WIDTH{1'b1}}) r_count <= r_count + COUNT_WIDTH'(1);
            if (in_inf) begin
              r_state <= in_last ? ST_OUTPUT : ST_ACCEPT;
            end else if (r_acc_inf) begin
              r_acc_x   <= w_in_x;
              r_acc_y   <= w_in_y;
              r_acc_inf <= 1'b0;
              r_state   <= in_last ? ST_OUTPUT : ST_ACCEPT;
            end else if (w_x_eq && w_y_eq && !w_y_zero) begin
              r_start <= 1'b1;
              r_state <= ST_DBL_WAIT;
            end else if (w_x_eq) begin
              // P + (-P), or doubling a point of order two
              r_acc_inf <= 1'b1;
              r_state   <= in_last ? ST_OUTPUT : ST_ACCEPT;
            end else begin
              r_start <= 1'b1;
              r_state <= ST_ADD_WAIT;
            end
          end
        end
        ST_ADD_WAIT: begin
          if (w_add_done) begin
            r_acc_x   <= w_add_res.x[P_WIDTH-1:0];
            r_acc_y   <= w_add_res.y[P_WIDTH-1:0];
            r_acc_inf <= 1'b0;
            r_state   <= r_last ? ST_OUTPUT : ST_ACCEPT;
          end
        end
        ST_DBL_WAIT: begin
          if (w_dbl_done) begin
            r_acc_x   <= w_dbl_res.x[P_WIDTH-1:0];
            r_acc_y   <= w_dbl_res.y[P_WIDTH-1:0];
            r_acc_inf <= 1'b0;
            r_state   <= r_last ? ST_OUTPUT : ST_ACCEPT;
          end
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            r_acc_x   <= '0;
            r_acc_y   <= '0;
            r_acc_inf <= 1'b1;
            r_count   <= '0;
            r_state   <= ST_ACCEPT;
          end
        end
        default: r_state <= ST_ACCEPT;
      endcase
    end
  end

  assign out_valid = (r_state == ST_OUTPUT);
  assign out_point = out_valid ? {r_acc_x, r_acc_y} : '0;
  assign out_inf   = out_valid && r_acc_inf;
  assign count     = r_count;
  assign busy      = (r_state != ST_ACCEPT);
endmodule

// File: tb/tb_msm_point_accumulator.sv
// Directed bench on the toy curve y^2 = x^3 + 2x + 2 over GF(17), G = (5,1):
// 2G = (6,3), 3G = (10,6), 4G = (3,1), -G = (5,16).
module tb_msm_point_accumulator;
  import msm_point_accumulator_pkg::*;

  localparam int PW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          in_valid = 1'b0, in_inf = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [2*PW-1:0] in_point = '0;
  logic          in_ready, out_valid, out_inf, busy;
  logic [2*PW-1:0] out_point;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_errors = 0;
  int n_add_start = 0;
  int n_dbl_start = 0;
  int a0, d0;

  msm_point_accumulator #(
    .P_WIDTH(PW), .COUNT_WIDTH(CW), .P_MOD(field_t'(17)), .CURVE_A(field_t'(2))
  ) dut (
    .clk(clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_point(in_point), .in_inf(in_inf), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_point(out_point),
    .out_inf(out_inf), .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dut.w_add_start) n_add_start <= n_add_start + 1;
    if (dut.w_dbl_start) n_dbl_start <= n_dbl_start + 1;
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [PW-1:0] x, input logic [PW-1:0] y,
                      input logic inf, input logic last);
    int waited = 0;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check_eq("send_timeout", 16'(in_ready), 16'd1);
    end else begin
      in_point = {x, y};
      in_inf   = inf;
      in_last  = last;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_inf   = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic expect_out(input string tag, input logic [PW-1:0] x, input logic [PW-1:0] y,
                            input logic inf, input logic [CW-1:0] cnt);
    int waited = 0;
    while (!out_valid && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check_eq({tag, "_valid"}, 16'(out_valid), 16'd1);
    if (out_valid) begin
      if (!inf) check_eq({tag, "_point"}, out_point, {x, y});
      check_eq({tag, "_inf"}, 16'(out_inf), 16'(inf));
      check_eq({tag, "_count"}, count, cnt);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_eq({tag, "_drop"}, 16'(out_valid), 16'd0);
      check_eq({tag, "_rdy_after"}, 16'(in_ready), 16'd1);
    end
  endtask

  initial begin
    int bad;
    int seen;
    // reset held
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", 16'(out_valid), 16'd0);
    check_eq("rst_out_point", out_point, 16'd0);
    check_eq("rst_out_inf", 16'(out_inf), 16'd0);
    check_eq("rst_busy", 16'(busy), 16'd0);
    check_eq("rst_in_ready", 16'(in_ready), 16'd0);
    check_eq("rst_count", count, 16'd0);
    Reset_n = 1'b1;
    @(negedge clk);
    check_eq("rel_in_ready", 16'(in_ready), 16'd1);

    // single G: pass-through load, result on the next cycle
    a0 = n_add_start; d0 = n_dbl_start;
    send(8'd5, 8'd1, 1'b0, 1'b1);
    check_eq("g_next_cycle", 16'(out_valid), 16'd1);
    expect_out("g", 8'd5, 8'd1, 1'b0, 16'd1);
    check_eq("g_no_start", 16'(n_add_start - a0 + n_dbl_start - d0), 16'd0);

    // G + G doubles
    a0 = n_add_start; d0 = n_dbl_start;
    send(8'd5, 8'd1, 1'b0, 1'b0);
    send(8'd5, 8'd1, 1'b0, 1'b1);
    check_eq("dbl_busy", 16'(busy), 16'd1);
    expect_out("2g", 8'd6, 8'd3, 1'b0, 16'd2);
    check_eq("2g_dbl_starts", 16'(n_dbl_start - d0), 16'd1);
    check_eq("2g_add_starts", 16'(n_add_start - a0), 16'd0);

    // G + 2G + G = 4G via two adds
    a0 = n_add_start;
    send(8'd5, 8'd1, 1'b0, 1'b0);
    send(8'd6, 8'd3, 1'b0, 1'b0);
    send(8'd5, 8'd1, 1'b0, 1'b1);
    expect_out("4g", 8'd3, 8'd1, 1'b0, 16'd3);
    check_eq("4g_add_starts", 16'(n_add_start - a0), 16'd2);

    // G + (-G) = infinity, no arithmetic
    a0 = n_add_start; d0 = n_dbl_start;
    send(8'd5, 8'd1, 1'b0, 1'b0);
    send(8'd5, 8'd16, 1'b0, 1'b1);
    expect_out("neg", 8'd0, 8'd0, 1'b1, 16'd2);
    check_eq("neg_no_start", 16'(n_add_start - a0 + n_dbl_start - d0), 16'd0);

    // inf, G, inf(last) with a 10-cycle output stall
    send(8'd0, 8'd0, 1'b1, 1'b0);
    send(8'd5, 8'd1, 1'b0, 1'b0);
    send(8'd0, 8'd0, 1'b1, 1'b1);
    bad = 0;
    repeat (10) begin
      if (out_valid !== 1'b1 || out_point !== {8'd5, 8'd1} || in_ready !== 1'b0 || out_inf !== 1'b0)
        bad++;
      @(negedge clk);
    end
    check_eq("stall_stable", 16'(bad), 16'd0);
    expect_out("infmix", 8'd5, 8'd1, 1'b0, 16'd3);

    // reset during ADD_WAIT aborts the batch
    send(8'd5, 8'd1, 1'b0, 1'b0);
    send(8'd6, 8'd3, 1'b0, 1'b1);
    check_eq("add_wait_busy", 16'(busy), 16'd1);
    Reset_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_out_valid", 16'(out_valid), 16'd0);
    check_eq("mid_rst_out_point", out_point, 16'd0);
    check_eq("mid_rst_out_inf", 16'(out_inf), 16'd0);
    check_eq("mid_rst_busy", 16'(busy), 16'd0);
    check_eq("mid_rst_count", count, 16'd0);
    Reset_n = 1'b1;
    @(negedge clk);
    check_eq("mid_rel_in_ready", 16'(in_ready), 16'd1);
    seen = 0;
    repeat (30) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check_eq("mid_rst_no_result", 16'(seen), 16'd0);
    send(8'd5, 8'd1, 1'b0, 1'b1);
    expect_out("post_rst", 8'd5, 8'd1, 1'b0, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
